// File: rtl/lemmings_splat.sv
// Purpose : walk/fall/dig lemming Moore controller that splats after a fall longer than FALL_LIMIT cycles.
// Latency : one clk from inputs to state and outputs; outputs decode only registered state (no input-to-output path).
// Backpres: none -- environment inputs are sampled every cycle, there is no handshake.
//
// Ports:
//   clk                      rising-edge clock
//   areset                   asynchronous active-low reset -> WALK_LEFT, fall_cnt = 0
//   bump_left / bump_right   obstacle on the left / right
//   ground                   1 = ground beneath the lemming
//   dig                      request to start digging
//   walk_left, walk_right,
//   aaah, digging, splat     one-hot Moore outputs
//   fall_cnt                 completed aaah cycles in the current fall, saturating at FALL_LIMIT

module lemmings_splat #(
    parameter  int FALL_LIMIT = 20,
    localparam int CNT_W      = $clog2(FALL_LIMIT + 1)
) (
    input  logic             clk,
    input  logic             areset,
    input  logic             bump_left,
    input  logic             bump_right,
    input  logic             ground,
    input  logic             dig,
    output logic             walk_left,
    output logic             walk_right,
    output logic             aaah,
    output logic             digging,
    output logic             splat,
    output logic [CNT_W-1:0] fall_cnt
);

    typedef enum logic [2:0] {
        WALK_LEFT  = 3'd0,
        WALK_RIGHT = 3'd1,
        FALL_LEFT  = 3'd2,
        FALL_RIGHT = 3'd3,
        DIG_LEFT   = 3'd4,
        DIG_RIGHT  = 3'd5,
        SPLAT      = 3'd6
    } state_t;

    localparam logic [CNT_W-1:0] LIMIT = CNT_W'(FALL_LIMIT);

    state_t           state;
    state_t           state_nxt;
    logic [CNT_W-1:0] cnt_nxt;
    logic             at_limit;
    logic [CNT_W-1:0] cnt_inc;

    // Landing decision uses the registered count: at_limit in the landing
    // cycle means FALL_LIMIT aaah cycles already completed before this one.
    assign at_limit = (fall_cnt >= LIMIT);
    // Saturate rather than wrap so arbitrarily long falls stay lethal.
    assign cnt_inc  = at_limit ? LIMIT : (fall_cnt + CNT_W'(1));

    always_ff @(posedge clk or negedge areset) begin
        if (!areset) begin
            state    <= WALK_LEFT;
            fall_cnt <= '0;
        end else begin
            state    <= state_nxt;
            fall_cnt <= cnt_nxt;
        end
    end

    always_comb begin
        // Defaults also cover the unused encoding: recover to WALK_LEFT, count 0.
        state_nxt  = WALK_LEFT;
        cnt_nxt    = '0;
        walk_left  = 1'b0;
        walk_right = 1'b0;
        aaah       = 1'b0;
        digging    = 1'b0;
        splat      = 1'b0;

        case (state)
            WALK_LEFT: begin
                walk_left = 1'b1;
                if (!ground)        state_nxt = FALL_LEFT;
                else if (dig)       state_nxt = DIG_LEFT;
                else if (bump_left) state_nxt = WALK_RIGHT;
                else                state_nxt = WALK_LEFT;
            end
            WALK_RIGHT: begin
                walk_right = 1'b1;
                if (!ground)         state_nxt = FALL_RIGHT;
                else if (dig)        state_nxt = DIG_RIGHT;
                else if (bump_right) state_nxt = WALK_LEFT;
                else                 state_nxt = WALK_RIGHT;
            end
            FALL_LEFT: begin
                aaah    = 1'b1;
                cnt_nxt = cnt_inc;
                if (!ground)       state_nxt = FALL_LEFT;
                else if (at_limit) state_nxt = SPLAT;
                else               state_nxt = WALK_LEFT;
            end
            FALL_RIGHT: begin
                aaah    = 1'b1;
                cnt_nxt = cnt_inc;
                if (!ground)       state_nxt = FALL_RIGHT;
                else if (at_limit) state_nxt = SPLAT;
                else               state_nxt = WALK_RIGHT;
            end
            DIG_LEFT: begin
                digging   = 1'b1;
                state_nxt = ground ? DIG_LEFT : FALL_LEFT;
            end
            DIG_RIGHT: begin
                digging   = 1'b1;
                state_nxt = ground ? DIG_RIGHT : FALL_RIGHT;
            end
            SPLAT: begin
                splat     = 1'b1;
                state_nxt = SPLAT;
            end
            default: begin
                state_nxt = WALK_LEFT;
            end
        endcase
    end

endmodule

// File: doc/lemmings_splat.md
Name: lemmings_splat

Overview:
- Parametrised successor to the walk/fall/dig lemming controller.
- Keeps the same walking, falling and digging behaviour.
- Adds a saturating fall-duration counter. A lemming that lands after falling more than FALL_LIMIT cycles enters a terminal SPLAT state and stays there until reset.
- Sits at the same level as the existing lemming FSMs: a standalone Moore controller driven directly by the environment inputs.

Parameters:
- FALL_LIMIT, 20: maximum number of fall cycles (aaah high) that are survivable. Legal range 1..1023.
- CNT_W, derived localparam = $clog2(FALL_LIMIT+1): width of the fall counter. Not user-overridable.

Ports:
- clk  input  1  system clock, rising-edge.
- areset  input  1  asynchronous, active-low reset. Low forces WALK_LEFT and clears the counter immediately.
- bump_left  input  1  obstacle on left.
- bump_right  input  1  obstacle on right.
- ground  input  1  1 = ground beneath lemming.
- dig  input  1  request to start digging.
- walk_left  output  1  high in WALK_LEFT.
- walk_right  output  1  high in WALK_RIGHT.
- aaah  output  1  high in FALL_LEFT or FALL_RIGHT.
- digging  output  1  high in DIG_LEFT or DIG_RIGHT.
- splat  output  1  high in SPLAT.
- fall_cnt  output  CNT_W  current fall counter value, for debug and verification.

Behaviour:
- Clock and reset: one clock; reset is asynchronous and active-low.
- Reset values: state WALK_LEFT, fall_cnt 0. Outputs: walk_left=1, all other outputs 0.
- Moore machine, 7 states:
  - WALK_LEFT, WALK_RIGHT, FALL_LEFT, FALL_RIGHT, DIG_LEFT, DIG_RIGHT, SPLAT.
  - Exactly one of walk_left, walk_right, aaah, digging, splat is high in every state.
- Transition priority from WALK_x: ground=0 beats dig, and dig beats bump.
  - ground=0 -> FALL_x.
  - else dig=1 -> DIG_x.
  - else bump toward the current direction -> walk in the opposite direction.
  - else stay.
- Bump direction rules:
  - WALK_LEFT reacts only to bump_left; WALK_RIGHT reacts only to bump_right.
  - Both bumps high behaves as the relevant bump only.
- DIG_x:
  - ground=0 -> FALL_x.
  - Otherwise stay. dig and bump are ignored.
- FALL_x:
  - bump and dig are ignored; direction is preserved.
  - ground=1 and fall_cnt >= FALL_LIMIT -> SPLAT.
  - ground=1 and fall_cnt < FALL_LIMIT -> WALK_x.
  - ground=0 -> stay.
- SPLAT:
  - Absorbing; all inputs are ignored.
  - Leaves only via areset low.
- Fall counter:
  - In any non-FALL state, next fall_cnt = 0.
  - In FALL_x, next fall_cnt = min(fall_cnt+1, FALL_LIMIT). It saturates and never wraps, however long the fall.
  - fall_cnt reads 0 on the first aaah cycle. It therefore equals the number of aaah cycles already completed.
- Survivability:
  - A fall of exactly FALL_LIMIT aaah cycles survives.
  - A fall of FALL_LIMIT+1 or more aaah cycles splats on landing.
- Next-state timing:
  - The state uses the registered counter value in the landing cycle.
  - No combinational path from inputs to outputs.
- Reset mid-operation (mid-fall, mid-dig, or in SPLAT):
  - areset low forces WALK_LEFT and fall_cnt=0 asynchronously.
  - The first state update is on the first clk edge after release.
- Undefined state encodings recover to WALK_LEFT with fall_cnt=0.

Test Plan:
- Reset sequence: areset low mid-cycle -> walk_left=1 immediately, others 0, fall_cnt=0. After release with ground=1, bump_left=1 -> walk_right=1 after one edge.
- Boundary fall (FALL_LIMIT=20): from WALK_RIGHT, ground=0 for exactly 20 edges, then ground=1 -> aaah high 20 cycles, fall_cnt 0..19, then walk_right=1, splat=0.
- Splat: ground=0 for 21 edges, then ground=1 -> splat=1 and all other outputs 0. Holds for 50 further cycles despite toggling ground, dig and bumps.
- Saturation and reset from SPLAT: ground=0 for 2000 cycles -> fall_cnt holds at 20 and never wraps. Landing -> splat=1. areset pulse -> walk_left=1.
- Priority: in WALK_LEFT drive ground=0, dig=1, bump_left=1 together -> FALL_LEFT. Later, on ground, dig=1 with bump_left=1 -> DIG_LEFT, and bumps are ignored while digging.
- Parameter sweep: FALL_LIMIT=1 and FALL_LIMIT=7, CNT_W=1/3 -> a fall of FALL_LIMIT cycles survives and FALL_LIMIT+1 splats.
